// File: rtl/sdram_stream_pkg.sv
// Shared sizing constants and FSM encoding for the SDRAM block-ring stream scheduler.
package sdram_stream_pkg;
   localparam int BLOCK_WORDS = 512;
   localparam int NUM_BLOCKS  = 8192;
   localparam int ADDR_W      = 22;
   localparam int PTR_W       = $clog2(NUM_BLOCKS);
   localparam int CNT_W       = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;
endpackage

// File: rtl/sdram_blk_ptr.sv
// Wrapping block pointer; a power-of-two ring makes the natural rollover the wrap.
module sdram_blk_ptr #(
   parameter int W = sdram_stream_pkg::PTR_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] ptr
);
   always_ff @(posedge clk) begin
      if (!rst_n)
         ptr <= '0;
      else if (inc)
         ptr <= ptr + W'(1);
   end
endmodule

// File: rtl/sdram_stream_scheduler.sv
// Schedules one-at-a-time write/read bursts between stream FIFOs and an SDRAM block ring.
module sdram_stream_scheduler #(
   parameter int BLOCK_WORDS = sdram_stream_pkg::BLOCK_WORDS,
   parameter int NUM_BLOCKS  = sdram_stream_pkg::NUM_BLOCKS,
   parameter int ADDR_W      = sdram_stream_pkg::ADDR_W
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [9:0]                  in_fifo_usedw,
   input  logic                        in_fifo_full,
   input  logic [9:0]                  out_fifo_usedw,
   input  logic                        out_fifo_full,
   output logic                        cmd_valid,
   output logic                        cmd_write,
   output logic [ADDR_W-1:0]           cmd_addr,
   input  logic                        cmd_ready,
   input  logic                        burst_done,
   output logic [$clog2(NUM_BLOCKS):0] blk_count,
   output logic                        sdram_full,
   output logic                        sdram_empty,
   output logic                        busy
);
   import sdram_stream_pkg::*;

   localparam int PW = $clog2(NUM_BLOCKS);
   localparam int CW = PW + 1;
   localparam int OW = $clog2(BLOCK_WORDS);

   state_t          state, state_nx;
   logic [PW-1:0]   wr_ptr, rd_ptr, sel_ptr;
   logic            last_write;
   logic            wr_req, rd_req, pick_write;
   logic            load, accept, done;

   assign sdram_full  = (blk_count == CW'(NUM_BLOCKS));
   assign sdram_empty = (blk_count == '0);
   assign busy        = (state != IDLE);

   assign wr_req = (({1'b0, in_fifo_usedw} >= 11'(BLOCK_WORDS)) || in_fifo_full) && !sdram_full;
   assign rd_req = (({1'b0, out_fifo_usedw} <= 11'(1024 - BLOCK_WORDS)) && !out_fifo_full) && !sdram_empty;

   // On a tie, serve the direction not granted last (last_write=0 resets to read).
   assign pick_write = wr_req && (!rd_req || !last_write);
   assign sel_ptr    = pick_write ? wr_ptr : rd_ptr;

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      accept   = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (wr_req || rd_req) begin
               state_nx = ISSUE;
               load     = 1'b1;
            end
         end
         ISSUE: begin
            if (cmd_ready) begin
               state_nx = WAIT_DONE;
               accept   = 1'b1;
            end
         end
         WAIT_DONE: begin
            if (burst_done) begin
               state_nx = IDLE;
               done     = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         cmd_valid  <= 1'b0;
         cmd_write  <= 1'b0;
         cmd_addr   <= '0;
         blk_count  <= '0;
         last_write <= 1'b0;
      end else begin
         state <= state_nx;
         if (load) begin
            cmd_valid <= 1'b1;
            cmd_write <= pick_write;
            cmd_addr  <= ADDR_W'({sel_ptr, OW'(0)});
         end
         if (accept)
            cmd_valid <= 1'b0;
         if (done) begin
            last_write <= cmd_write;
            if (cmd_write)
               blk_count <= blk_count + CW'(1);
            else
               blk_count <= blk_count - CW'(1);
         end
      end
   end

   sdram_blk_ptr #(.W(PW)) u_wr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (done && cmd_write),
      .ptr   (wr_ptr)
   );

   sdram_blk_ptr #(.W(PW)) u_rd_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (done && !cmd_write),
      .ptr   (rd_ptr)
   );
endmodule
